// File: rtl/umi_simple_host.sv
// umi_simple_host
//   Minimal UMI host bridge. A local single-word read/write request is
//   captured, issued on the UMI request channel, and (unless posted) the
//   matching UMI response is awaited with a bounded timeout. Completion
//   is signalled by a one-cycle host_done pulse carrying rdata/err.
//
// Ports
//   clk, nreset          : clock, asynchronous active-low reset
//   host_valid/write/posted/addr/wdata : local request (in)
//   host_ready           : local request accepted when high (IDLE only)
//   host_done            : one-cycle completion pulse
//   host_rdata, host_err : completion result, held until the next completion
//   host_stray           : pulse when an unexpected response is discarded
//   uhost_req_*          : UMI request channel (out, ready in)
//   uhost_resp_*         : UMI response channel (in, ready out)

module umi_simple_host #(
    parameter int unsigned      CW      = 32,
    parameter int unsigned      AW      = 64,
    parameter int unsigned      DW      = 32,
    parameter logic [AW-1:0]    SRCADDR = 64'h0,
    parameter int unsigned      TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          nreset,
    // local host side
    input  logic          host_valid,
    input  logic          host_write,
    input  logic          host_posted,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ready,
    output logic          host_done,
    output logic [DW-1:0] host_rdata,
    output logic          host_err,
    output logic          host_stray,
    // UMI request channel
    output logic          uhost_req_valid,
    output logic [CW-1:0] uhost_req_cmd,
    output logic [AW-1:0] uhost_req_dstaddr,
    output logic [AW-1:0] uhost_req_srcaddr,
    output logic [DW-1:0] uhost_req_data,
    input  logic          uhost_req_ready,
    // UMI response channel
    input  logic          uhost_resp_valid,
    input  logic [CW-1:0] uhost_resp_cmd,
    input  logic [AW-1:0] uhost_resp_dstaddr,
    input  logic [AW-1:0] uhost_resp_srcaddr,
    input  logic [DW-1:0] uhost_resp_data,
    output logic          uhost_resp_ready
);

    localparam logic [4:0]  OP_READ       = 5'h01;
    localparam logic [4:0]  OP_WRITE      = 5'h03;
    localparam logic [4:0]  OP_POSTED     = 5'h05;
    localparam logic [4:0]  OP_RESP_READ  = 5'h02;
    localparam logic [4:0]  OP_RESP_WRITE = 5'h04;
    localparam logic [15:0] TO_LAST       = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [15:0]   cnt;
    logic          cap_write;
    logic          cap_posted;
    logic [CW-1:0] req_cmd;
    logic [AW-1:0] req_dstaddr;
    logic [DW-1:0] req_data;
    logic [DW-1:0] rdata_q;
    logic          err_q;
    logic [CW-1:0] cmd_new;
    logic          accept;
    logic          req_hs;
    logic          expired;
    logic          resp_ok;

    // Response fields other than the opcode are not needed for a single
    // outstanding single-word transaction.
    logic unused_resp;
    assign unused_resp = ^{uhost_resp_dstaddr, uhost_resp_srcaddr,
                           uhost_resp_cmd[CW-1:5]};

    assign accept  = (state == IDLE) && host_valid;
    assign req_hs  = (state == REQ) && uhost_req_ready;
    assign expired = (cnt >= TO_LAST);
    assign resp_ok = (uhost_resp_cmd[4:0] ==
                      (cap_write ? OP_RESP_WRITE : OP_RESP_READ));

    always_comb begin
        cmd_new      = '0;
        cmd_new[4:0] = !host_write ? OP_READ :
                       (host_posted ? OP_POSTED : OP_WRITE);
        cmd_new[7:5] = 3'd2;
        cmd_new[22]  = 1'b1;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (host_valid) state_next = REQ;
            REQ:     if (uhost_req_ready) state_next = cap_posted ? DONE : WAIT;
            WAIT:    if (uhost_resp_valid || expired) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt         <= '0;
            cap_write   <= 1'b0;
            cap_posted  <= 1'b0;
            req_cmd     <= '0;
            req_dstaddr <= '0;
            req_data    <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            if (accept) begin
                cap_write   <= host_write;
                cap_posted  <= host_write & host_posted;
                req_cmd     <= cmd_new;
                req_dstaddr <= host_addr;
                req_data    <= host_write ? host_wdata : '0;
            end
            if (req_hs) begin
                cnt <= '0;
                if (cap_posted) begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
            end
            if (state == WAIT) begin
                // A response arriving in the expiry cycle takes priority.
                if (uhost_resp_valid) begin
                    err_q   <= !resp_ok;
                    rdata_q <= (resp_ok && !cap_write) ? uhost_resp_data : '0;
                end else if (expired) begin
                    err_q   <= 1'b1;
                    rdata_q <= '0;
                end else if (cnt != 16'hFFFF) begin
                    cnt <= cnt + 16'd1;
                end
            end
        end
    end

    // Ready outputs are gated by reset so they read 0 while it is held.
    assign host_ready        = nreset && (state == IDLE);
    assign uhost_resp_ready  = nreset;
    assign host_done         = (state == DONE);
    assign host_rdata        = rdata_q;
    assign host_err          = err_q;
    assign host_stray        = nreset && uhost_resp_valid && (state != WAIT);

    assign uhost_req_valid   = (state == REQ);
    assign uhost_req_cmd     = req_cmd;
    assign uhost_req_dstaddr = req_dstaddr;
    assign uhost_req_srcaddr = (state == REQ) ? SRCADDR : '0;
    assign uhost_req_data    = req_data;

endmodule

// File: doc/umi_simple_host.md
UMI_SIMPLE_HOST -- requirements
Module: umi_simple_host

Interface
REQ-001 Parameters SHALL be (name, default, meaning): CW, 32, UMI command width.
REQ-002 AW, 64, UMI address width.
REQ-003 DW, 32, UMI data width (single-word transactions only).
REQ-004 SRCADDR, 64'h0, return address driven on every request srcaddr.
REQ-005 TIMEOUT, 1024, response wait limit in cycles (16-bit counter).
REQ-006 Ports (name, direction, width, meaning): clk, in, 1, sole clock; reset is asynchronous and active-low.
REQ-007 nreset, in, 1, asynchronous active-low reset.
REQ-008 host_valid, in, 1, local access request.
REQ-009 host_write, in, 1, 1=write, 0=read.
REQ-010 host_posted, in, 1, write without response (ignored when host_write=0).
REQ-011 host_addr, in, AW, target address.
REQ-012 host_wdata, in, DW, write data.
REQ-013 host_ready, out, 1, block accepts a local request.
REQ-014 host_done, out, 1, one-cycle completion pulse.
REQ-015 host_rdata, out, DW, read data, valid with host_done.
REQ-016 host_err, out, 1, timeout or bad response, valid with host_done.
REQ-017 host_stray, out, 1, one-cycle pulse on discarded unexpected response.
REQ-018 uhost_req_valid/cmd/dstaddr/srcaddr/data, out, 1/CW/AW/AW/DW, UMI request channel.
REQ-019 uhost_req_ready, in, 1, UMI request ready.
REQ-020 uhost_resp_valid/cmd/dstaddr/srcaddr/data, in, 1/CW/AW/AW/DW, UMI response channel.
REQ-021 uhost_resp_ready, out, 1, UMI response ready.

Function
REQ-022 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-023 host_ready SHALL be 1 only in IDLE; host_valid&host_ready SHALL capture addr/wdata/write/posted and move to REQ.
REQ-024 In REQ, uhost_req_valid SHALL be 1 with stable fields until uhost_req_valid&uhost_req_ready; first valid cycle is the cycle after local accept.
REQ-025 cmd SHALL be opcode[4:0] (READ=5'h01, WRITE=5'h03, POSTED=5'h05), size[7:5]=3'd2, len[15:8]=0, eom[22]=1, all other bits 0.
REQ-026 dstaddr=captured addr, srcaddr=SRCADDR, data=captured wdata for writes, 0 for reads.
REQ-027 On request handshake: posted write -> DONE; otherwise -> WAIT with timeout counter cleared.
REQ-028 uhost_resp_ready SHALL be 1 in all states after reset release; responses outside WAIT SHALL be discarded and pulse host_stray.
REQ-029 In WAIT, response with opcode RESP_READ (5'h02) for read or RESP_WRITE (5'h04) for write -> DONE, host_err=0, host_rdata=resp data (reads) or 0 (writes).
REQ-030 In WAIT, response with any other opcode -> DONE, host_err=1, host_rdata=0.
REQ-031 In WAIT, counter increments each cycle without response; counter reaching TIMEOUT-1 -> DONE with host_err=1, host_rdata=0.
REQ-032 Response in the same cycle the counter expires SHALL win (no error).
REQ-033 DONE SHALL last exactly one cycle with host_done=1, then return to IDLE; host_rdata/host_err SHALL hold until next DONE.
REQ-034 Counter SHALL saturate, never wrap.

Reset
REQ-035 nreset low SHALL asynchronously force IDLE, counter 0, all outputs 0 (host_ready and uhost_resp_ready 0 while reset asserted), including mid-transaction; in-flight request abandoned, late response after reset reported as stray.
REQ-036 First cycle after nreset deasserts: host_ready=1, uhost_resp_ready=1.

Verification
REQ-037 Write addr 0x100 data 0xDEADBEEF, responder returns RESP_WRITE -> cmd 0x00400043, host_done, host_err=0.
REQ-038 Read addr 0x100 after REQ-037, responder returns data 0xDEADBEEF -> cmd 0x00400041, host_rdata=0xDEADBEEF, host_err=0.
REQ-039 Posted write with uhost_req_ready held low 5 cycles -> valid/fields stable 6 cycles, host_done cycle after handshake, no WAIT.
REQ-040 TIMEOUT=16 read, no response -> host_done with host_err=1 exactly 16 cycles after entering WAIT; later response pulses host_stray.
REQ-041 Read answered with RESP_WRITE opcode -> host_err=1, host_rdata=0.
REQ-042 nreset asserted in WAIT -> outputs 0 immediately, host_ready=1 one cycle after release.
